// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 inverse cipher: one round per clock around a shared
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns datapath.

module inverseSubBytes (
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            data_o[127-8*i -: 8] = inv_sbox(data_i[127-8*i -: 8]);
        end
    end

endmodule

module aes_inv_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy,
    output logic [3:0]   round
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_q, round_d;

    logic [127:0] isr, isb, ark, imc;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8, r;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        r  = k[0] ? a : 8'h00;
        if (k[1]) r = r ^ a2;
        if (k[2]) r = r ^ a4;
        if (k[3]) r = r ^ a8;
        return r;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   b0, b1, b2, b3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            b0 = s[127-32*c -: 8];
            b1 = s[119-32*c -: 8];
            b2 = s[111-32*c -: 8];
            b3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = mul(b0, 4'he) ^ mul(b1, 4'hb) ^ mul(b2, 4'hd) ^ mul(b3, 4'h9);
            o[119-32*c -: 8] = mul(b0, 4'h9) ^ mul(b1, 4'he) ^ mul(b2, 4'hb) ^ mul(b3, 4'hd);
            o[111-32*c -: 8] = mul(b0, 4'hd) ^ mul(b1, 4'h9) ^ mul(b2, 4'he) ^ mul(b3, 4'hb);
            o[103-32*c -: 8] = mul(b0, 4'hb) ^ mul(b1, 4'hd) ^ mul(b2, 4'h9) ^ mul(b3, 4'he);
        end
        return o;
    endfunction

    always_comb isr = inv_shift_rows(state_q);

    inverseSubBytes u_inv_sub_bytes (
        .data_i (isr),
        .data_o (isb)
    );

    always_comb ark = isb ^ rk;
    always_comb imc = inv_mix_columns(ark);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        round_d   = round_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rk_idx    = 4'd0;
        case (fsm_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                rk_idx   = 4'd10;
                if (in_valid) begin
                    state_d = ciphertext ^ rk;
                    round_d = 4'd9;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                rk_idx  = round_q;
                state_d = imc;
                if (round_q == 4'd1) fsm_d = S_FINAL;
                else                 round_d = round_q - 4'd1;
            end
            S_FINAL: begin
                rk_idx  = 4'd0;
                state_d = ark;
                round_d = 4'd0;
                fsm_d   = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign plaintext = state_q;
    assign round     = round_q;

endmodule
